iob_2p_assim_fifo_r_big: RTL and testbench

Synchronous FIFO with asymmetric ports: a narrow write port and a wide read port, where R_DATA_W is an integer power-of-two multiple of W_DATA_W. It packs consecutive narrow words into one wide word, least-significant first. It sits between narrow producers (byte streams, UART/SPI receivers) and wide consumers (bus masters, wide datapaths). It complements the wide-write/narrow-read memory, adding pointer, occupancy and flag control.

---
 rtl/iob_2p_assim_fifo_r_big.sv | 104 ++++++++++
 tb/tb_iob_2p_assim_fifo_r_big.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iob_2p_assim_fifo_r_big.sv
// Synchronous FIFO with a narrow write port and a wide read port.
// Narrow words are packed least-significant first into each wide read word.
module iob_2p_assim_fifo_r_big #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] data_in,
  output logic                full,
  output logic                w_err,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] data_out,
  output logic                empty,
  output logic                r_err,
  output logic [ADDR_W:0]     level
);

  localparam int RATIO    = R_DATA_W / W_DATA_W;
  localparam int R_LOG    = $clog2(RATIO);
  localparam int R_ADDR_W = ADDR_W - R_LOG;
  localparam int DEPTH    = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   RATIO_L = (ADDR_W + 1)'(RATIO);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] W_INC_L = ADDR_W'(1);
  localparam logic [R_ADDR_W-1:0] R_INC_L = R_ADDR_W'(1);

  logic [W_DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]   w_ptr_r;
  logic [R_ADDR_W-1:0] r_ptr_r;
  logic [ADDR_W:0]     level_r;
  logic [ADDR_W:0]     level_nxt_s;
  logic                full_r;
  logic                empty_r;
  logic                w_err_r;
  logic                r_err_r;
  logic [R_DATA_W-1:0] data_out_r;
  logic                w_acc_s;
  logic                r_acc_s;

  // Acceptance uses only the flags registered before this edge.
  assign w_acc_s = w_en && !full_r;
  assign r_acc_s = r_en && !empty_r;

  // Next occupancy from accepted write/read combination.
  always_comb begin
    level_nxt_s = level_r;
    case ({w_acc_s, r_acc_s})
      2'b10:   level_nxt_s = level_r + ONE_L;
      2'b01:   level_nxt_s = level_r - RATIO_L;
      2'b11:   level_nxt_s = level_r + ONE_L - RATIO_L;
      default: level_nxt_s = level_r;
    endcase
  end

  // Narrow-word storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_acc_s) begin
      mem_r[w_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy, flags, error pulses and wide read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_r    <= '0;
      r_ptr_r    <= '0;
      level_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      w_err_r    <= 1'b0;
      r_err_r    <= 1'b0;
      data_out_r <= '0;
    end else begin
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == DEPTH_L);
      empty_r <= (level_nxt_s < RATIO_L);
      w_err_r <= w_en && full_r;
      r_err_r <= r_en && empty_r;
      if (w_acc_s) begin
        w_ptr_r <= w_ptr_r + W_INC_L;
      end
      if (r_acc_s) begin
        r_ptr_r <= r_ptr_r + R_INC_L;
        // Storage reads see only words committed on earlier edges.
        for (int i = 0; i < RATIO; i++) begin
          data_out_r[i*W_DATA_W +: W_DATA_W] <= mem_r[{r_ptr_r, R_LOG'(i)}];
        end
      end
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign w_err    = w_err_r;
  assign r_err    = r_err_r;
  assign level    = level_r;
  assign data_out = data_out_r;

endmodule

// File: tb/tb_iob_2p_assim_fifo_r_big.sv
// Directed self-checking bench for the narrow-write / wide-read FIFO
// (8-bit write, 16-bit read, depth 8).
module tb_iob_2p_assim_fifo_r_big;

  localparam int W_DATA_W = 8;
  localparam int R_DATA_W = 16;
  localparam int ADDR_W   = 3;

  logic                clk;
  logic                rst;
  logic                w_en;
  logic [W_DATA_W-1:0] data_in;
  logic                full;
  logic                w_err;
  logic                r_en;
  logic [R_DATA_W-1:0] data_out;
  logic                empty;
  logic                r_err;
  logic [ADDR_W:0]     level;

  int n_checks = 0;
  int n_fail   = 0;

  iob_2p_assim_fifo_r_big #(
    .W_DATA_W(W_DATA_W),
    .R_DATA_W(R_DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .w_en    (w_en),
    .data_in (data_in),
    .full    (full),
    .w_err   (w_err),
    .r_en    (r_en),
    .data_out(data_out),
    .empty   (empty),
    .r_err   (r_err),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle #1 after it.
  task automatic cyc(input logic we, input logic [7:0] d, input logic re);
    w_en    = we;
    data_in = d;
    r_en    = re;
    @(posedge clk);
    #1;
    w_en    = 1'b0;
    r_en    = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  wb;
    int          rd;
    int          cycles;
    logic        we;
    logic        re;
    logic [15:0] exp_w;

    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    #12;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_errs", {30'd0, w_err, r_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic pack of two bytes
    cyc(1'b1, 8'h11, 1'b0);
    chk("t1_empty1", 32'(empty), 32'd1);
    chk("t1_level1", 32'(level), 32'd1);
    cyc(1'b1, 8'h22, 1'b0);
    chk("t1_empty2", 32'(empty), 32'd0);
    chk("t1_level2", 32'(level), 32'd2);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t1_dout", 32'(data_out), 32'h2211);
    chk("t1_level0", 32'(level), 32'd0);
    chk("t1_empty3", 32'(empty), 32'd1);

    // Fill to full, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd8);
    cyc(1'b1, 8'h09, 1'b0);
    chk("t2_werr", 32'(w_err), 32'd1);
    chk("t2_level_hold", 32'(level), 32'd8);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_werr_pulse", 32'(w_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      exp_w = {8'(2*i + 2), 8'(2*i + 1)};
      chk("t2_read", 32'(data_out), 32'(exp_w));
    end
    chk("t2_level0", 32'(level), 32'd0);

    // Read while below RATIO
    cyc(1'b1, 8'h31, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t3_rerr", 32'(r_err), 32'd1);
    chk("t3_dout_hold", 32'(data_out), 32'h0807);
    chk("t3_level", 32'(level), 32'd1);
    cyc(1'b1, 8'h32, 1'b1);
    chk("t3_rerr2", 32'(r_err), 32'd1);
    chk("t3_level2", 32'(level), 32'd2);
    chk("t3_empty", 32'(empty), 32'd0);
    chk("t3_dout_hold2", 32'(data_out), 32'h0807);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t3_dout", 32'(data_out), 32'h3231);
    chk("t3_rerr_clr", 32'(r_err), 32'd0);

    // Simultaneous read and write at full
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(8'h41 + i), 1'b0);
    end
    chk("t4_full", 32'(full), 32'd1);
    cyc(1'b1, 8'h49, 1'b1);
    chk("t4_werr", 32'(w_err), 32'd1);
    chk("t4_rerr", 32'(r_err), 32'd0);
    chk("t4_level", 32'(level), 32'd6);
    chk("t4_dout", 32'(data_out), 32'h4241);
    chk("t4_full_clr", 32'(full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      exp_w = {8'(8'h44 + 2*i), 8'(8'h43 + 2*i)};
      chk("t4_drain", 32'(data_out), 32'(exp_w));
    end
    chk("t4_level0", 32'(level), 32'd0);

    // Wrap-around stream with random write gaps
    wb = 8'd0; rd = 0; cycles = 0;
    while (rd < 20 && cycles < 500) begin
      we = (wb < 8'd40) && ($urandom_range(0, 3) != 0);
      re = !empty;
      cyc(we, 8'(8'hC0 + wb), re);
      if (we) wb++;
      if (re) begin
        exp_w = {8'(8'hC0 + 2*rd + 1), 8'(8'hC0 + 2*rd)};
        chk("t5_word", 32'(data_out), 32'(exp_w));
        rd++;
      end
      chk("t5_errs", {30'd0, w_err, r_err}, 32'd0);
      cycles++;
    end
    chk("t5_reads", 32'(rd), 32'd20);
    chk("t5_level", 32'(level), 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(8'h50 + i), 1'b0);
    end
    chk("t6_level5", 32'(level), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_dout", 32'(data_out), 32'd0);
    #2;
    rst = 1'b0;
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_read", 32'(data_out), 32'hBBAA);
    chk("t6_level_end", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
